// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame constants and
// the default bit-timing derivation for a 50 MHz clock at 115200 baud.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned SYS_CLK_HZ = 50_000_000;
  localparam int unsigned BAUD_RATE  = 115_200;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

  localparam int unsigned DEFAULT_CLKS_PER_BIT = calc_clks_per_bit(SYS_CLK_HZ, BAUD_RATE);

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with push/pop, occupancy level and full/empty flags.
// Read data is the current head entry; no bypass from push to pop.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full     = (level_q == FULL_LEVEL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter: input FIFO feeding a start/data/stop serializer,
// LSB first, with a registered glitch-free tx output.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST   = 1'(STOP_BITS - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $fatal(1, "uart_tx_engine: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_tx_engine: STOP_BITS must be 1 or 2");
  end

  tx_state_e              state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   baud_zero;

  logic                   fifo_push, fifo_pop;
  logic [DATA_BITS-1:0]   fifo_data;
  logic                   fifo_full, fifo_empty;

  assign fifo_push = in_valid && in_ready;
  assign in_ready  = !fifo_full;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    baud_zero = (baud_q == '0);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          baud_d   = BAUD_RELOAD;
          state_d  = START;
        end
      end
      START: begin
        if (baud_zero) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_zero) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            stop_d  = STOP_LAST;
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_zero) begin
          if (stop_q == 1'b0) begin
            // Chain straight into the next start bit so frames have no idle gap.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_data;
              baud_d   = BAUD_RELOAD;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = stop_q - 1'b1;
            baud_d = BAUD_RELOAD;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
